// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y using one full-subtractor cell over W cycles, LSB first.
// Two operand pairs (a,b) / (c,d) share the datapath; sel picks one when start is accepted.
// Optional signed overflow flag: define SERIAL_SUBTRACTOR_SIGNED_OVF_EN to build it; otherwise ovf is tied low.
module serial_subtractor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         ovf
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    xr, yr, res;
    logic [CW-1:0]   cnt;
    logic            br, d_i, br_nx, last, accept;

    // One full-subtractor cell on the current LSBs plus the registered borrow
    always_comb begin
        d_i    = xr[0] ^ yr[0] ^ br;
        br_nx  = (~xr[0] & yr[0]) | (~(xr[0] ^ yr[0]) & br);
        last   = cnt == CW'(W - 1);
        accept = start && state != RUN;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: RUN exits after bit W-1; DONE and IDLE both accept start
    always_comb begin
        state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    // Status outputs decoded from state
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    // Operand load, per-bit shift and result capture at DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr     <= '0;
            yr     <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            xr  <= sel ? c : a;
            yr  <= sel ? d : b;
            res <= '0;
            cnt <= '0;
            br  <= 1'b0;
        end else if (state == RUN) begin
            res <= {d_i, res[W-1:1]};
            xr  <= xr >> 1;
            yr  <= yr >> 1;
            cnt <= cnt + 1'b1;
            br  <= br_nx;
            if (last) begin
                diff   <= {d_i, res[W-1:1]};
                borrow <= br_nx;
            end
        end
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic xs, ys;

    // Operand signs are kept so overflow can be judged once the result MSB is known
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs  <= 1'b0;
            ys  <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            xs <= sel ? c[W-1] : a[W-1];
            ys <= sel ? d[W-1] : b[W-1];
        end else if (state == RUN && last) begin
            ovf <= (xs ^ ys) & (xs ^ d_i);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
